// File: rtl/crossword_vram_writer_pkg.sv
// Shared types, geometry constants and small cursor-arithmetic helpers
// for the crossword VRAM writer.
package crossword_pkg;

    localparam int GRID_ROWS  = 5;
    localparam int GRID_COLS  = 5;
    localparam int CELL_W_CH  = 10;
    localparam int CELL_H_CH  = 5;
    localparam int ORIGIN_COL = 5;
    localparam int ORIGIN_ROW = 7;
    localparam int WORDS_ROW  = 40;
    localparam int NUM_CELLS  = GRID_ROWS * GRID_COLS;

    localparam logic [7:0] CELL_COLOR  = 8'h10;
    localparam logic [7:0] CHAR_BLANK  = 8'h20;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_Z     = 8'h1D;
    localparam logic [7:0] KC_BKSP  = 8'h2A;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_UP    = 8'h52;

    // Distance from a HID letter usage code to its ASCII capital ('A' - 0x04).
    localparam logic [7:0] KC_TO_ASCII = 8'h3D;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ERASE,
        DRAW
    } state_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } cell_t;

    localparam cell_t LAST_CELL = '{row: 3'(GRID_ROWS - 1), col: 3'(GRID_COLS - 1)};

    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v == lim - 3'd1) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] wrap_dec(input logic [2:0] v, input logic [2:0] lim);
        return (v == 3'd0) ? lim - 3'd1 : v - 3'd1;
    endfunction

    function automatic cell_t next_raster(input cell_t c);
        cell_t n;
        n.col = wrap_inc(c.col, 3'(GRID_COLS));
        n.row = (c.col == 3'(GRID_COLS - 1)) ? wrap_inc(c.row, 3'(GRID_ROWS)) : c.row;
        return n;
    endfunction

    function automatic logic [4:0] cell_index(input cell_t c);
        return 5'(32'(c.row) * 32'(GRID_COLS) + 32'(c.col));
    endfunction

endpackage

// File: rtl/crossword_vram_writer_if.sv
// Keyboard key stream and VRAM write port bundled as one interface;
// master is the writer, slave is the keyboard/VRAM side.
interface crossword_vram_writer_if;
    logic        key_valid;
    logic [7:0]  keycode;
    logic        key_ready;
    logic        wr_req;
    logic        wr_gnt;
    logic [11:0] wr_addr;
    logic [3:0]  wr_byte_en;
    logic [31:0] wr_data;

    modport master (
        input  key_valid,
        input  keycode,
        output key_ready,
        output wr_req,
        input  wr_gnt,
        output wr_addr,
        output wr_byte_en,
        output wr_data
    );

    modport slave (
        output key_valid,
        output keycode,
        input  key_ready,
        input  wr_req,
        output wr_gnt,
        input  wr_addr,
        input  wr_byte_en,
        input  wr_data
    );
endinterface

// File: rtl/crossword_vram_writer_cell_addr.sv
// Maps a grid cell plus its character to a VRAM word address, byte lanes
// and lane-aligned write data; used by every write state.
module crossword_cell_addr
    import crossword_pkg::*;
(
    input  cell_t       cell_i,
    input  logic [6:0]  letter_i,
    input  logic        iv_i,
    output logic [11:0] addr_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] data_o
);

    logic [11:0] trow;
    logic [11:0] tcol;
    logic [7:0]  char_code;

    always_comb begin
        trow      = 12'(ORIGIN_ROW) + 12'(cell_i.row) * 12'(CELL_H_CH);
        tcol      = 12'(ORIGIN_COL) + 12'(cell_i.col) * 12'(CELL_W_CH);
        addr_o    = trow * 12'(WORDS_ROW) + (tcol >> 1);
        char_code = {iv_i, letter_i};
        // Two text characters share a word; odd columns live in the upper half.
        if (tcol[0]) begin
            byte_en_o = 4'b1100;
            data_o    = {char_code, CELL_COLOR, 16'h0000};
        end else begin
            byte_en_o = 4'b0011;
            data_o    = {16'h0000, char_code, CELL_COLOR};
        end
    end

endmodule

// File: rtl/crossword_vram_writer.sv
// Keyboard-driven 5x5 crossword editor that paints letters and an inverse
// cursor into text-mode VRAM. Define AUTO_ADVANCE_EN to step the cursor after each letter.
module crossword_vram_writer
    import crossword_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    crossword_vram_writer_if.master bus,
    output logic [2:0]             cursor_row,
    output logic [2:0]             cursor_col,
    output logic                   busy
);

    state_t      state_q, state_d;
    cell_t       cursor_q, cursor_d;
    cell_t       old_q, old_d;
    cell_t       init_q, init_d;
    logic        wr_req_q, wr_req_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [3:0]  wr_be_q, wr_be_d;
    logic [31:0] wr_data_q, wr_data_d;

    // Shadow copy of the letters so redraws never need to read VRAM back.
    logic [7:0]  shadow_q [NUM_CELLS];
    logic        sh_we;
    logic [4:0]  sh_widx;
    logic [7:0]  sh_wdata;

    cell_t       src_cell;
    logic [6:0]  src_letter;
    logic        src_iv;
    logic [11:0] cell_addr;
    logic [3:0]  cell_be;
    logic [31:0] cell_data;

    crossword_cell_addr u_cell_addr (
        .cell_i    (src_cell),
        .letter_i  (src_letter),
        .iv_i      (src_iv),
        .addr_o    (cell_addr),
        .byte_en_o (cell_be),
        .data_o    (cell_data)
    );

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        old_d      = old_q;
        init_d     = init_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_be_d    = wr_be_q;
        wr_data_d  = wr_data_q;
        sh_we      = 1'b0;
        sh_widx    = cell_index(cursor_q);
        sh_wdata   = CHAR_BLANK;
        src_cell   = cursor_q;
        src_letter = CHAR_BLANK[6:0];
        src_iv     = 1'b0;

        unique case (state_q)
            INIT: src_cell = init_q;
            ERASE: begin
                src_cell   = old_q;
                src_letter = shadow_q[cell_index(old_q)][6:0];
            end
            DRAW: begin
                src_letter = shadow_q[cell_index(cursor_q)][6:0];
                src_iv     = 1'b1;
            end
            default: ;
        endcase

        if (state_q == IDLE) begin
            if (bus.key_valid) begin
                if (bus.keycode >= KC_A && bus.keycode <= KC_Z) begin
                    sh_we    = 1'b1;
                    sh_wdata = bus.keycode + KC_TO_ASCII;
`ifdef AUTO_ADVANCE_EN
                    old_d    = cursor_q;
                    cursor_d = next_raster(cursor_q);
                    state_d  = ERASE;
`else
                    state_d  = DRAW;
`endif
                end else begin
                    unique case (bus.keycode)
                        KC_BKSP: begin
                            sh_we   = 1'b1;
                            state_d = DRAW;
                        end
                        KC_RIGHT: begin
                            old_d        = cursor_q;
                            cursor_d.col = wrap_inc(cursor_q.col, 3'(GRID_COLS));
                            state_d      = ERASE;
                        end
                        KC_LEFT: begin
                            old_d        = cursor_q;
                            cursor_d.col = wrap_dec(cursor_q.col, 3'(GRID_COLS));
                            state_d      = ERASE;
                        end
                        KC_DOWN: begin
                            old_d        = cursor_q;
                            cursor_d.row = wrap_inc(cursor_q.row, 3'(GRID_ROWS));
                            state_d      = ERASE;
                        end
                        KC_UP: begin
                            old_d        = cursor_q;
                            cursor_d.row = wrap_dec(cursor_q.row, 3'(GRID_ROWS));
                            state_d      = ERASE;
                        end
                        default: ;
                    endcase
                end
            end
        end else if (!wr_req_q) begin
            // Load phase: present the current write; it then waits for a grant.
            wr_req_d  = 1'b1;
            wr_addr_d = cell_addr;
            wr_be_d   = cell_be;
            wr_data_d = cell_data;
        end else if (bus.wr_gnt) begin
            wr_req_d = 1'b0;
            unique case (state_q)
                INIT: begin
                    if (init_q == LAST_CELL) begin
                        init_d  = '0;
                        state_d = DRAW;
                    end else begin
                        init_d = next_raster(init_q);
                    end
                end
                ERASE:   state_d = DRAW;
                DRAW:    state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= INIT;
            cursor_q  <= '0;
            old_q     <= '0;
            init_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            old_q     <= old_d;
            init_q    <= init_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            wr_data_q <= wr_data_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_shadow
        always_ff @(posedge CLK) begin
            if (RESET) begin
                shadow_q[gi] <= CHAR_BLANK;
            end else if (sh_we && sh_widx == 5'(gi)) begin
                shadow_q[gi] <= sh_wdata;
            end
        end
    end

    assign bus.key_ready  = (state_q == IDLE);
    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_byte_en = wr_be_q;
    assign bus.wr_data    = wr_data_q;
    assign cursor_row     = cursor_q.row;
    assign cursor_col     = cursor_q.col;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_crossword_vram_writer.sv
// Self-checking bench for crossword_vram_writer: fixed vector table, reset and
// stall corner cases, and random keys checked against a behavioural grid model.
module tb_crossword_vram_writer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] cursor_row;
    logic [2:0] cursor_col;
    logic       busy;

    crossword_vram_writer_if bus ();

    crossword_vram_writer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  key;
        int          n;
        logic [11:0] a0;
        logic [31:0] d0;
        logic [11:0] a1;
        logic [31:0] d1;
        int          row;
        int          col;
    } vec_t;

    wr_t        wq[$];
    wr_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         gnt_mode = 0;
    logic [7:0] m_sh [25];
    int         m_r = 0;
    int         m_c = 0;
    vec_t       tbl [11];

    initial forever #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Grant driver: 0 = always grant, 1 = random, 2 = withhold.
    initial begin
        bus.wr_gnt = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (gnt_mode)
                0:       bus.wr_gnt = 1'b1;
                1:       bus.wr_gnt = 1'($urandom_range(0, 1));
                default: bus.wr_gnt = 1'b0;
            endcase
        end
    end

    // A write completes on the edge following a negedge that sees req and grant.
    always @(negedge CLK) begin
        if (RESET === 1'b0 && bus.wr_req === 1'b1 && bus.wr_gnt === 1'b1)
            wq.push_back('{bus.wr_addr, bus.wr_byte_en, bus.wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: cell geometry straight from the text-layout rules.
    function automatic void push_cell(input int r, input int c, input bit iv);
        wr_t        w;
        logic [7:0] ch;
        int         tcol;
        ch     = {iv, m_sh[r * 5 + c][6:0]};
        tcol   = 5 + 10 * c;
        w.addr = 12'((7 + 5 * r) * 40 + tcol / 2);
        if (tcol % 2 == 1) begin
            w.be   = 4'b1100;
            w.data = {ch, 8'h10, 16'h0000};
        end else begin
            w.be   = 4'b0011;
            w.data = {16'h0000, ch, 8'h10};
        end
        exp_q.push_back(w);
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 25; i++) m_sh[i] = 8'h20;
        m_r = 0;
        m_c = 0;
        exp_q.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                push_cell(r, c, 1'b0);
        push_cell(0, 0, 1'b1);
    endfunction

    function automatic void model_key(input logic [7:0] k);
        exp_q.delete();
        if (k >= 8'h04 && k <= 8'h1D) begin
            m_sh[m_r * 5 + m_c] = k - 8'h04 + 8'h41;
`ifdef AUTO_ADVANCE_EN
            push_cell(m_r, m_c, 1'b0);
            m_c = m_c + 1;
            if (m_c == 5) begin
                m_c = 0;
                m_r = (m_r + 1) % 5;
            end
`endif
            push_cell(m_r, m_c, 1'b1);
        end else if (k == 8'h2A) begin
            m_sh[m_r * 5 + m_c] = 8'h20;
            push_cell(m_r, m_c, 1'b1);
        end else if (k >= 8'h4F && k <= 8'h52) begin
            push_cell(m_r, m_c, 1'b0);
            case (k)
                8'h4F:   m_c = (m_c + 1) % 5;
                8'h50:   m_c = (m_c + 4) % 5;
                8'h51:   m_r = (m_r + 1) % 5;
                default: m_r = (m_r + 4) % 5;
            endcase
            push_cell(m_r, m_c, 1'b1);
        end
    endfunction

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
        n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wq[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_be%0d", tag, i), 32'(wq[i].be), 32'(exp_q[i].be));
            check($sformatf("%s_data%0d", tag, i), wq[i].data, exp_q[i].data);
        end
        check({tag, "_cursor"}, 32'({cursor_row, cursor_col}), 32'({3'(m_r), 3'(m_c)}));
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (bus.wr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_req_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic send_key(input logic [7:0] k);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.key_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("key_ready_timeout", 32'(ok), 32'd1);
        bus.key_valid = 1'b1;
        bus.keycode   = k;
        @(posedge CLK);
        #1;
        bus.key_valid = 1'b0;
        bus.keycode   = 8'h00;
    endtask

    task automatic run_model_key(input logic [7:0] k, input string tag);
        model_key(k);
        wq.delete();
        send_key(k);
        wait_idle(tag, 500);
        $display("%s: key %h writes=%0d cursor=(%0d,%0d)", tag, k, wq.size(), cursor_row, cursor_col);
        compare_writes(tag);
    endtask

    initial begin
        logic [7:0] k;
        bus.key_valid = 1'b0;
        bus.keycode   = 8'h00;

        // Reset values, then the power-up INIT sweep with grant tied high.
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_key_ready", 32'(bus.key_ready), 32'd0);
        check("rst_wr_req", 32'(bus.wr_req), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_be", 32'(bus.wr_byte_en), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        RESET = 1'b0;
        wq.delete();
        model_init();
        wait_idle("t1", 500);
        $display("t1: init writes=%0d", wq.size());
        compare_writes("t1");
        if (wq.size() == 26) begin
            check("t1_last_blank_addr", 32'(wq[24].addr), 32'd1102);
            check("t1_draw_addr", 32'(wq[25].addr), 32'd282);
            check("t1_draw_data", wq[25].data, 32'hA010_0000);
        end
        check("t1_key_ready", 32'(bus.key_ready), 32'd1);

        // Grant withheld for 10 cycles during DRAW.
        gnt_mode = 2;
        wq.delete();
        send_key(8'h2A);
        wait_req("t5", 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("t5_hold_req", 32'(bus.wr_req), 32'd1);
            check("t5_hold_addr", 32'(bus.wr_addr), 32'd282);
            check("t5_hold_data", bus.wr_data, 32'hA010_0000);
            check("t5_hold_key_ready", 32'(bus.key_ready), 32'd0);
        end
        gnt_mode = 0;
        wait_idle("t5", 50);
        $display("t5: stalled draw writes=%0d", wq.size());
        check("t5_one_write", 32'(wq.size()), 32'd1);

        // Fixed vectors from cursor (0,0) with a blank grid.
        tbl[0]  = '{8'h50, 2, 12'd282, 32'h2010_0000, 12'd302, 32'hA010_0000, 0, 4};
        tbl[1]  = '{8'h4F, 2, 12'd302, 32'h2010_0000, 12'd282, 32'hA010_0000, 0, 0};
        tbl[2]  = '{8'h52, 2, 12'd282, 32'h2010_0000, 12'd1082, 32'hA010_0000, 4, 0};
        tbl[3]  = '{8'h51, 2, 12'd1082, 32'h2010_0000, 12'd282, 32'hA010_0000, 0, 0};
        tbl[4]  = '{8'h00, 0, 12'd0, 32'h0, 12'd0, 32'h0, 0, 0};
        tbl[5]  = '{8'h2A, 1, 12'd282, 32'hA010_0000, 12'd0, 32'h0, 0, 0};
        tbl[6]  = '{8'h51, 2, 12'd282, 32'h2010_0000, 12'd482, 32'hA010_0000, 1, 0};
        tbl[7]  = '{8'hFF, 0, 12'd0, 32'h0, 12'd0, 32'h0, 1, 0};
`ifdef AUTO_ADVANCE_EN
        tbl[8]  = '{8'h1D, 2, 12'd482, 32'h5A10_0000, 12'd487, 32'hA010_0000, 1, 1};
        tbl[9]  = '{8'h04, 2, 12'd487, 32'h4110_0000, 12'd492, 32'hA010_0000, 1, 2};
        tbl[10] = '{8'h50, 2, 12'd492, 32'h2010_0000, 12'd487, 32'hC110_0000, 1, 1};
`else
        tbl[8]  = '{8'h1D, 1, 12'd482, 32'hDA10_0000, 12'd0, 32'h0, 1, 0};
        tbl[9]  = '{8'h04, 1, 12'd482, 32'hC110_0000, 12'd0, 32'h0, 1, 0};
        tbl[10] = '{8'h50, 2, 12'd482, 32'h4110_0000, 12'd502, 32'hA010_0000, 1, 4};
`endif
        gnt_mode = 1;
        for (int i = 0; i < 11; i++) begin
            wq.delete();
            send_key(tbl[i].key);
            wait_idle($sformatf("vec%0d", i), 500);
            $display("vec%0d: key %h writes=%0d cursor=(%0d,%0d)", i, tbl[i].key, wq.size(), cursor_row, cursor_col);
            check($sformatf("vec%0d_count", i), 32'(wq.size()), 32'(tbl[i].n));
            if (tbl[i].n >= 1 && wq.size() >= 1) begin
                check($sformatf("vec%0d_addr0", i), 32'(wq[0].addr), 32'(tbl[i].a0));
                check($sformatf("vec%0d_data0", i), wq[0].data, tbl[i].d0);
                check($sformatf("vec%0d_be0", i), 32'(wq[0].be), 32'(4'b1100));
            end
            if (tbl[i].n >= 2 && wq.size() >= 2) begin
                check($sformatf("vec%0d_addr1", i), 32'(wq[1].addr), 32'(tbl[i].a1));
                check($sformatf("vec%0d_data1", i), wq[1].data, tbl[i].d1);
                check($sformatf("vec%0d_be1", i), 32'(wq[1].be), 32'(4'b1100));
            end
            check($sformatf("vec%0d_cursor", i), 32'({cursor_row, cursor_col}),
                  32'({3'(tbl[i].row), 3'(tbl[i].col)}));
        end

        // Reset while an ERASE write is pending.
        gnt_mode = 2;
        wq.delete();
        send_key(8'h4F);
        wait_req("t6", 20);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("t6_req_dropped", 32'(bus.wr_req), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        RESET = 1'b0;
        wq.delete();
        gnt_mode = 1;
        model_init();
        wait_idle("t6", 2000);
        $display("t6: reinit writes=%0d", wq.size());
        compare_writes("t6_init");
        run_model_key(8'h51, "t6_blank");
        run_model_key(8'h50, "t6_blank2");

        // Random keys against the model, random grant timing.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: k = 8'(8'h04 + $urandom_range(0, 25));
                4, 5, 6, 7: k = 8'(8'h4F + $urandom_range(0, 3));
                8:          k = 8'h2A;
                default:    k = 8'($urandom_range(0, 255));
            endcase
            run_model_key(k, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
